weight_tile_loader: RTL and testbench

Fetches weight tiles from external weight memory and streams them, one 64-bit row per cycle, into the datapath's weight FIFO write port (`wt_fifo_data` / `wt_fifo_wr`). It sits directly upstream of the TPU datapath and replaces the controller's raw `wt_mem_rd_en` / `wt_mem_addr` / `wt_num_tiles` strobes with a credit-limited request/response engine. Backpressure comes from a FIFO-full flag.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/wt_rsp_fifo.sv | 58 +++++
 rtl/weight_tile_loader.sv | 136 +++++++++++++
 tb/tb_weight_tile_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU weight path.
package tpu_pkg;

    typedef enum logic [1:0] {
        WTL_IDLE,
        WTL_ISSUE,
        WTL_DRAIN,
        WTL_FINISH
    } wtl_state_e;

    localparam int WT_ROW_BYTES = 8;

    typedef logic [63:0] wt_row_t;

endpackage

// File: rtl/wt_rsp_fifo.sv
// Response buffer between the memory read port and the weight FIFO output register.
module wt_rsp_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wt_row_t          push_data,
    input  logic             pop,
    input  logic             flush,
    output wt_row_t          head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wt_row_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: the storage array has no reset; count gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/weight_tile_loader.sv
// Credit-limited weight tile fetch engine: issues row reads to weight memory and
// streams the returned rows into the datapath weight FIFO.
module weight_tile_loader
    import tpu_pkg::*;
#(
    parameter int ROWS_PER_TILE = 3,
    parameter int RSP_DEPTH     = 4,
    parameter int ADDR_W        = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_tiles,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  wt_row_t           mem_rsp_data,
    input  logic              wt_fifo_full,
    output logic              wt_fifo_wr,
    output wt_row_t           wt_fifo_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    wtl_state_e       state;
    wtl_state_e       state_next;
    logic [ADDR_W-1:0] addr;
    logic [9:0]       rows_left;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] buf_count;
    logic             aborting;
    wt_row_t          buf_head;
    logic             buf_empty;
    logic             launch;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_take;
    logic             rsp_push;
    logic             pop;
    logic             flush;
    logic             drained;

    // Abort beats a simultaneous start.
    assign launch    = (state == WTL_IDLE) && start && !abort;
    assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < (CNT_W + 1)'(RSP_DEPTH);

    assign mem_req_valid = (state == WTL_ISSUE) && !abort && (rows_left != 10'd0) && credit_ok;
    assign mem_req_addr  = addr;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses with nothing outstanding (e.g. in IDLE) are dropped; during abort they are absorbed.
    assign flush    = abort || aborting;
    assign rsp_take = mem_rsp_valid && (state != WTL_IDLE) && (outstanding != '0);
    assign rsp_push = rsp_take && !flush;
    assign pop      = !buf_empty && !wt_fifo_full && !flush;

    // Exit DRAIN one cycle early when the final row is being popped, so done trails the last write by one.
    assign drained = (outstanding == '0) &&
                     (buf_empty || flush || ((buf_count == CNT_W'(1)) && pop));

    wt_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data (mem_rsp_data),
        .pop       (pop),
        .flush     (flush),
        .head      (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // NOTE: next state defaults to the current state first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            WTL_IDLE:   if (launch) state_next = (num_tiles == 8'd0) ? WTL_FINISH : WTL_ISSUE;
            WTL_ISSUE:  if (abort || (req_fire && rows_left == 10'd1)) state_next = WTL_DRAIN;
            WTL_DRAIN:  if (drained) state_next = WTL_FINISH;
            WTL_FINISH: state_next = WTL_IDLE;
            default:    state_next = WTL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WTL_IDLE;
            addr        <= '0;
            rows_left   <= '0;
            outstanding <= '0;
            aborting    <= 1'b0;
        end else begin
            state <= state_next;

            if (launch) begin
                addr      <= base_addr;
                rows_left <= 10'(num_tiles * ROWS_PER_TILE);
            end else if (req_fire) begin
                addr      <= addr + ADDR_W'(WT_ROW_BYTES);
                rows_left <= rows_left - 10'd1;
            end

            case ({req_fire, rsp_take})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (state == WTL_FINISH) begin
                aborting <= 1'b0;
            end else if (abort && state != WTL_IDLE) begin
                aborting <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_fifo_wr   <= 1'b0;
            wt_fifo_data <= '0;
            done         <= 1'b0;
        end else begin
            wt_fifo_wr <= pop;
            if (pop) wt_fifo_data <= buf_head;
            done <= (state == WTL_FINISH);
        end
    end

    assign busy = (state != WTL_IDLE);

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader with a small in-order memory responder.
module tb_weight_tile_loader;
    import tpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [23:0] base_addr;
    logic [7:0]  num_tiles;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [23:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        wt_fifo_full;
    logic        wt_fifo_wr;
    logic [63:0] wt_fifo_data;
    logic        busy;
    logic        done;

    weight_tile_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .num_tiles     (num_tiles),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wt_fifo_full  (wt_fifo_full),
        .wt_fifo_wr    (wt_fifo_wr),
        .wt_fifo_data  (wt_fifo_data),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    rsp_t        pend_q[$];
    logic [23:0] req_q[$];
    logic [63:0] wr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int          cycle, lat, full_lo, full_hi;
    bit          rdy_mode;
    logic [31:0] rdy_pat;
    int          acc_cnt, wr_cnt, done_cnt, done_cycle, last_wr_cycle;
    int          first_req_cycle, first_rsp_cycle, first_wr_cycle;
    int          stall_events, stall_viol, max_inflight, wr_after_full;
    int          busy_cnt, valid_cnt, pend_at_done;
    bit          busy_at_done, prev_stall, prev_full;
    logic [23:0] prev_addr;

    function automatic logic [63:0] row_of(input logic [23:0] a);
        return {8'h5A, a, 8'hA5, ~a};
    endfunction

    function automatic logic [63:0] wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 64'hx;
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (i < req_q.size()) ? {40'd0, req_q[i]} : 64'hx;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        cycle = 0; lat = 2; rdy_mode = 1'b0; rdy_pat = '1; full_lo = 0; full_hi = 0;
        acc_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cycle = -1; last_wr_cycle = -1;
        first_req_cycle = -1; first_rsp_cycle = -1; first_wr_cycle = -1;
        stall_events = 0; stall_viol = 0; max_inflight = 0; wr_after_full = 0;
        busy_cnt = 0; valid_cnt = 0; pend_at_done = -1;
        busy_at_done = 1'b1; prev_stall = 1'b0; prev_full = 1'b0; prev_addr = '0;
        pend_q.delete(); req_q.delete(); wr_q.delete();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    // One clock cycle: drive the memory side, log requests, then sample registered outputs.
    task automatic tick();
        mem_req_ready = rdy_mode ? rdy_pat[cycle % 32] : 1'b1;
        wt_fifo_full  = (cycle >= full_lo) && (cycle < full_hi);
        if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend_q[0].data;
            pend_q.delete(0);
            if (first_rsp_cycle < 0) first_rsp_cycle = cycle;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
        if (prev_stall) begin
            stall_events++;
            if (!mem_req_valid || mem_req_addr !== prev_addr) stall_viol++;
        end
        if (mem_req_valid) valid_cnt++;
        if (mem_req_valid && mem_req_ready) begin
            acc_cnt++;
            req_q.push_back(mem_req_addr);
            pend_q.push_back('{due: cycle + lat, data: row_of(mem_req_addr)});
            if (first_req_cycle < 0) first_req_cycle = cycle;
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        prev_full  = wt_fifo_full;
        @(posedge clk);
        #1;
        cycle++;
        if (busy) busy_cnt++;
        if (wt_fifo_wr) begin
            wr_cnt++;
            wr_q.push_back(wt_fifo_data);
            last_wr_cycle = cycle;
            if (first_wr_cycle < 0) first_wr_cycle = cycle;
            if (prev_full) wr_after_full++;
        end
        if (acc_cnt - wr_cnt > max_inflight) max_inflight = acc_cnt - wr_cnt;
        if (done) begin
            done_cnt++;
            done_cycle   = cycle;
            busy_at_done = busy;
            pend_at_done = pend_q.size();
        end
    endtask

    task automatic launch(input logic [23:0] base, input logic [7:0] tiles);
        base_addr = base;
        num_tiles = tiles;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_load();
        while (done_cnt == 0 && cycle < 300) tick();
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; num_tiles = '0;
        mem_req_ready = 1'b0; wt_fifo_full = 1'b0;
        reset_stats();

        // Reset values
        #3;
        check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_req_addr",  {40'd0, mem_req_addr},  64'd0);
        check("rst_fifo_wr",   {63'd0, wt_fifo_wr},    64'd0);
        check("rst_fifo_data", wt_fifo_data,           64'd0);
        check("rst_busy",      {63'd0, busy},          64'd0);
        check("rst_done",      {63'd0, done},          64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load: one tile at 0x100, latency 2
        reset_stats();
        launch(24'h000100, 8'd1);
        finish_load();
        check("basic_req_cnt",   acc_cnt,   3);
        check("basic_req0",      req_at(0), 64'h100);
        check("basic_req1",      req_at(1), 64'h108);
        check("basic_req2",      req_at(2), 64'h110);
        check("basic_wr_cnt",    wr_cnt,    3);
        check("basic_data0",     wr_at(0),  64'h5A000100_A5FFFEFF);
        check("basic_data1",     wr_at(1),  64'h5A000108_A5FFFEF7);
        check("basic_data2",     wr_at(2),  64'h5A000110_A5FFFEEF);
        check("basic_first_req", first_req_cycle, 1);
        check("basic_rsp_to_wr", first_wr_cycle - first_rsp_cycle, 2);
        check("basic_done_cnt",  done_cnt,  1);
        check("basic_done_cyc",  done_cycle, 8);
        check("basic_done_after_wr", done_cycle - last_wr_cycle, 1);
        check("basic_busy_at_done", {63'd0, busy_at_done}, 64'd0);

        // Zero tiles
        reset_stats();
        launch(24'h000100, 8'd0);
        finish_load();
        check("zero_valid_cnt", valid_cnt,  0);
        check("zero_done_cnt",  done_cnt,   1);
        check("zero_done_cyc",  done_cycle, 2);
        check("zero_busy_cyc",  busy_cnt,   1);

        // Request backpressure: fixed irregular ready pattern over 4 tiles
        reset_stats();
        rdy_mode = 1'b1;
        rdy_pat  = 32'b1011_0010_1101_0011_0110_1001_1100_0101;
        launch(24'h002000, 8'd4);
        finish_load();
        check("bp_stalls_seen", {63'd0, stall_events > 0}, 64'd1);
        check("bp_addr_stable", stall_viol, 0);
        check("bp_req_cnt",     acc_cnt,    12);
        check("bp_wr_cnt",      wr_cnt,     12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("bp_req%0d", i),  req_at(i), {40'd0, 24'h002000 + 24'(8 * i)});
            check($sformatf("bp_data%0d", i), wr_at(i),  row_of(24'h002000 + 24'(8 * i)));
        end
        check("bp_done_cnt", done_cnt, 1);

        // FIFO backpressure: full held for 10 cycles mid-load
        reset_stats();
        full_lo = 4;
        full_hi = 14;
        launch(24'h004000, 8'd4);
        finish_load();
        check("fb_max_inflight",   max_inflight,  4);
        check("fb_wr_after_full",  wr_after_full, 0);
        check("fb_wr_cnt",         wr_cnt,        12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("fb_data%0d", i), wr_at(i), row_of(24'h004000 + 24'(8 * i)));
        end
        check("fb_done_cnt", done_cnt, 1);

        // Address wrap
        reset_stats();
        launch(24'hFFFFF8, 8'd1);
        finish_load();
        check("wrap_req0",  req_at(0), 64'hFFFFF8);
        check("wrap_req1",  req_at(1), 64'h000000);
        check("wrap_req2",  req_at(2), 64'h000008);
        check("wrap_data0", wr_at(0),  64'h5AFFFFF8_A5000007);
        check("wrap_data1", wr_at(1),  64'h5A000000_A5FFFFFF);
        check("wrap_data2", wr_at(2),  64'h5A000008_A5FFFFF7);

        // Start and abort together in IDLE: nothing starts
        reset_stats();
        abort = 1'b1;
        launch(24'h000100, 8'd1);
        abort = 1'b0;
        repeat (5) tick();
        check("sa_busy_cnt",  busy_cnt,  0);
        check("sa_valid_cnt", valid_cnt, 0);
        check("sa_done_cnt",  done_cnt,  0);

        // Abort after two rows written, memory latency 4
        reset_stats();
        lat = 4;
        launch(24'h006000, 8'd2);
        while (wr_cnt < 2 && cycle < 100) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_no_wr_next", wr_cnt, 2);
        finish_load();
        check("ab_wr_total",   wr_cnt,   2);
        check("ab_req_cnt",    acc_cnt,  5);
        check("ab_data0",      wr_at(0), row_of(24'h006000));
        check("ab_data1",      wr_at(1), row_of(24'h006008));
        check("ab_done_cnt",   done_cnt, 1);
        check("ab_rsp_absorbed", pend_at_done, 0);
        check("ab_busy_at_done", {63'd0, busy_at_done}, 64'd0);

        // Clean load after abort: no stale rows leak through
        reset_stats();
        launch(24'h008000, 8'd1);
        finish_load();
        check("post_wr_cnt", wr_cnt,   3);
        check("post_data0",  wr_at(0), row_of(24'h008000));
        check("post_data2",  wr_at(2), row_of(24'h008010));
        check("post_done",   done_cnt, 1);

        // Reset asserted mid-load
        reset_stats();
        launch(24'h00A000, 8'd4);
        repeat (6) tick();
        check("mr_pre_busy", {63'd0, busy},       64'd1);
        check("mr_pre_wr",   {63'd0, wt_fifo_wr}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("mr_req_addr",  {40'd0, mem_req_addr},  64'd0);
        check("mr_fifo_wr",   {63'd0, wt_fifo_wr},    64'd0);
        check("mr_fifo_data", wt_fifo_data,           64'd0);
        check("mr_busy",      {63'd0, busy},          64'd0);
        check("mr_done",      {63'd0, done},          64'd0);
        reset_stats();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("mr_idle_after", busy_cnt + valid_cnt + wr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
